// File: rtl/bus_arbiter4.sv
// bus_arbiter4 -- four-way round-robin owner of the shared 16-bit write-back bus.
// Grants one requester at a time, registers its data onto O for every beat it
// drives, and inserts one idle turnaround cycle between owners.
// Optional feature: define ARB_BURST_LIMIT_EN to force a release after
// MAX_BURST beats. When undefined, the owner holds the bus until it drops req.
module bus_arbiter4 #(
    parameter int MAX_BURST = 8
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [3:0]  req,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [15:0] C,
    input  logic [15:0] D,
    output logic [3:0]  gnt,
    output logic [1:0]  S,
    output logic [15:0] O,
    output logic        valid,
    output logic        busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

    logic [0:0]  r_state;
    logic [3:0]  r_gnt;
    logic [1:0]  r_sel;
    logic [1:0]  r_last;
    logic [15:0] r_out;
    logic        r_valid;
    logic [7:0]  r_cnt;

    logic [1:0]  w_p1, w_p2, w_p3;
    logic [1:0]  w_next;
    logic        w_any;
    logic        w_beat;
    logic        w_cap_hit;
    logic        w_limit;
    logic [15:0] w_mux;

    // Round-robin search: first requester after the previous owner, previous owner last.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_p1   = r_last + 2'd1;
        w_p2   = r_last + 2'd2;
        w_p3   = r_last + 2'd3;
        w_next = r_last;
        if (req[w_p1])      w_next = w_p1;
        else if (req[w_p2]) w_next = w_p2;
        else if (req[w_p3]) w_next = w_p3;
        w_any = |req;
    end

    // Datapath mux driven by the registered select, so O never depends on inputs combinationally.
    always_comb begin
        w_mux = A;
        case (r_sel)
            2'd0:    w_mux = A;
            2'd1:    w_mux = B;
            2'd2:    w_mux = C;
            default: w_mux = D;
        endcase
    end

    // Beat qualification and the optional burst cap on the beat completing this edge.
    always_comb begin
        w_beat    = req[r_sel];
        w_cap_hit = ((r_cnt + 8'd1) == MAX_BURST_C);
`ifdef ARB_BURST_LIMIT_EN
        w_limit   = w_cap_hit;
`else
        // Counter still runs, but the cap is compiled out.
        w_limit   = 1'b0 && w_cap_hit;
`endif
    end

    // Ownership state machine with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'd0;
            r_last  <= 2'd3;
            r_out   <= 16'h0000;
            r_valid <= 1'b0;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_valid <= 1'b0;
                    if (w_any) begin
                        r_state <= ST_OWN;
                        r_gnt   <= 4'b0001 << w_next;
                        r_sel   <= w_next;
                        r_last  <= w_next;
                    end
                end
                ST_OWN: begin
                    if (w_beat) begin
                        r_out   <= w_mux;
                        r_valid <= 1'b1;
                        if (w_limit) begin
                            r_state <= ST_IDLE;
                            r_gnt   <= 4'b0000;
                            r_cnt   <= 8'd0;
                        end else begin
                            r_cnt   <= r_cnt + 8'd1;
                        end
                    end else begin
                        // Owner dropped req: release without counting a beat.
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                        r_gnt   <= 4'b0000;
                        r_cnt   <= 8'd0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 4'b0000;
                    r_valid <= 1'b0;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign S     = r_sel;
    assign O     = r_out;
    assign valid = r_valid;
    assign busy  = (r_state == ST_OWN);

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed bench for bus_arbiter4: reset state, round-robin order, burst
// handshake, reset mid-burst, and either the burst cap (ARB_BURST_LIMIT_EN
// defined, MAX_BURST=4) or indefinite ownership (macro undefined).
module tb_bus_arbiter4;

    logic        CLK;
    logic        Reset;
    logic [3:0]  req;
    logic [15:0] A, B, C, D;
    logic [3:0]  gnt;
    logic [1:0]  S;
    logic [15:0] O;
    logic        valid;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int beats    = 0;

    bus_arbiter4 #(.MAX_BURST(4)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .req   (req),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D),
        .gnt   (gnt),
        .S     (S),
        .O     (O),
        .valid (valid),
        .busy  (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] vals [4];
        vals[0] = 16'hAAAA; vals[1] = 16'hBBBB; vals[2] = 16'hCCCC; vals[3] = 16'hDDDD;
        Reset = 1'b1;
        req   = 4'b0000;
        A = vals[0]; B = vals[1]; C = vals[2]; D = vals[3];

        // Reset state
        step(); step();
        check("rst_gnt", 16'(gnt), 16'h0);
        check("rst_S", 16'(S), 16'h0);
        check("rst_O", O, 16'h0000);
        check("rst_valid", 16'(valid), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);

        // All request after reset: last=3, so requester 0 wins
        Reset = 1'b0;
        req   = 4'b1111;
        step();
        check("first_gnt", 16'(gnt), 16'h1);
        check("first_busy", 16'(busy), 16'h1);
        check("first_valid", 16'(valid), 16'h0);

        // Round robin, each owner gives one beat then releases
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_beat_valid", 16'(valid), 16'h1);
            check("rr_beat_O", O, vals[k]);
            check("rr_beat_gnt", 16'(gnt), 16'(4'b0001 << k));
            req = 4'b1111 & ~(4'b0001 << k);
            step();
            check("rr_rel_gnt", 16'(gnt), 16'h0);
            check("rr_rel_valid", 16'(valid), 16'h0);
            check("rr_rel_busy", 16'(busy), 16'h0);
            check("rr_rel_O_hold", O, vals[k]);
            req = 4'b1111;
            step();
            check("rr_next_gnt", 16'(gnt), 16'(4'b0001 << ((k + 1) % 4)));
            check("rr_next_S", 16'(S), 16'((k + 1) % 4));
            check("rr_next_valid", 16'(valid), 16'h0);
        end

        // Release owner 0, then requester 1 alone for 3 beats
        B   = 16'h1234;
        req = 4'b0010;
        step();
        check("b_rel_gnt", 16'(gnt), 16'h0);
        step();
        check("b_gnt", 16'(gnt), 16'h2);
        check("b_S", 16'(S), 16'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("b_valid", 16'(valid), 16'h1);
            check("b_O", O, 16'h1234);
            check("b_gnt_hold", 16'(gnt), 16'h2);
        end
        req = 4'b0000;
        step();
        check("b_end_gnt", 16'(gnt), 16'h0);
        check("b_end_valid", 16'(valid), 16'h0);
        check("b_end_O", O, 16'h1234);
        step();
        check("b_idle_gnt", 16'(gnt), 16'h0);
        check("b_idle_busy", 16'(busy), 16'h0);

        // Reset on beat 3 of requester 2
        req = 4'b0100;
        step();
        check("r2_gnt", 16'(gnt), 16'h4);
        step();
        check("r2_beat1_O", O, 16'hCCCC);
        step();
        check("r2_beat2_valid", 16'(valid), 16'h1);
        Reset = 1'b1;
        step();
        check("mid_rst_gnt", 16'(gnt), 16'h0);
        check("mid_rst_valid", 16'(valid), 16'h0);
        check("mid_rst_O", O, 16'h0000);
        check("mid_rst_S", 16'(S), 16'h0);
        check("mid_rst_busy", 16'(busy), 16'h0);
        Reset = 1'b0;
        req   = 4'b0101;
        step();
        check("post_rst_gnt0", 16'(gnt), 16'h1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        req   = 4'b0100;
        step();
        check("post_rst_gnt2", 16'(gnt), 16'h4);
        req = 4'b0000;
        step();
        check("r2_rel_gnt", 16'(gnt), 16'h0);

        // Continuous req=0101 from idle with last=2: requester 0 wins
        req = 4'b0101;
        step();
        check("cont_gnt", 16'(gnt), 16'h1);
        check("cont_valid0", 16'(valid), 16'h0);
`ifdef ARB_BURST_LIMIT_EN
        for (int i = 0; i < 3; i++) begin
            step();
            check("cap0_gnt", 16'(gnt), 16'h1);
            check("cap0_valid", 16'(valid), 16'h1);
        end
        step();
        check("cap0_rel_gnt", 16'(gnt), 16'h0);
        check("cap0_rel_valid", 16'(valid), 16'h1);
        check("cap0_rel_O", O, 16'hAAAA);
        step();
        check("cap2_gnt", 16'(gnt), 16'h4);
        check("cap2_valid0", 16'(valid), 16'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("cap2_gnt_hold", 16'(gnt), 16'h4);
            check("cap2_O", O, 16'hCCCC);
        end
        step();
        check("cap2_rel_gnt", 16'(gnt), 16'h0);
        check("cap2_rel_valid", 16'(valid), 16'h1);
        step();
        check("cap_back0_gnt", 16'(gnt), 16'h1);

        // Requester 3 drops on what would be its capped beat 4
        req = 4'b1000;
        step();
        check("sim_rel0_gnt", 16'(gnt), 16'h0);
        step();
        check("sim_gnt3", 16'(gnt), 16'h8);
        for (int i = 0; i < 3; i++) begin
            step();
            if (valid === 1'b1) beats++;
        end
        req = 4'b0001;
        step();
        check("sim_rel_gnt", 16'(gnt), 16'h0);
        check("sim_rel_valid", 16'(valid), 16'h0);
        check("sim_beats", 16'(beats), 16'd3);
        step();
        check("sim_next_gnt", 16'(gnt), 16'h1);
`else
        for (int i = 0; i < 100; i++) begin
            step();
            check("hold_gnt", 16'(gnt), 16'h1);
            check("hold_valid", 16'(valid), 16'h1);
        end
        check("hold_O", O, 16'hAAAA);
        req = 4'b0000;
        step();
        check("hold_rel_gnt", 16'(gnt), 16'h0);
        check("hold_rel_valid", 16'(valid), 16'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter4.md
# bus_arbiter4

Round-robin arbiter that shares the 16-bit 4:1 datapath mux between four requesters and drives a single registered 16-bit result bus. It owns the mux select and sequences ownership with a request/grant handshake. It sits between the four datapath sources (register file, ALU, immediate unit, memory port) and the shared write-back bus. Ownership is held for a burst, optionally capped in length, and is followed by a one-cycle turnaround.

## Interface
- MAX_BURST, 8, beats allowed per grant when the burst limit is compiled in; legal range 1..255.
- CLK  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset, sampled on the rising edge of CLK.
- req  in  4  request per requester; bit i = requester i.
- A, B, C, D  in  16 each  data from requesters 0, 1, 2, 3.
- gnt  out  4  one-hot grant, or all zero; registered.
- S  out  2  mux select, equal to the encoded owner; registered.
- O  out  16  registered bus data.
- valid  out  1  O carries a new beat this cycle.
- busy  out  1  high in the OWN state.

## Operation
- States:
  - IDLE: gnt=0, busy=0.
  - OWN: exactly one gnt bit set, busy=1.
- Round-robin pointer `last` (2 bits) holds the most recent owner.
- Reset values: state=IDLE, gnt=4'b0000, S=2'b00, O=16'h0000, valid=0, busy=0, last=3, beat counter=0.
- IDLE → OWN:
  - If any req bit is set at an edge, grant the first requester set in the order last+1, last+2, last+3, last (mod 4).
  - Set gnt, S, last, and state=OWN on that edge.
- A beat is any OWN cycle with req[owner]=1.
  - At the end of each beat: O<=selected input (A/B/C/D per S), valid<=1, beat counter +1 (8-bit).
  - In any non-beat cycle: valid<=0 and O holds its value.
- OWN → IDLE occurs on the edge where either:
  - req[owner]=0 is sampled, or
  - under the burst limit, the beat just completed is beat number MAX_BURST.
- On OWN → IDLE: gnt<=0, counter<=0. S and last hold their values.
- IDLE always lasts at least one cycle (turnaround). No direct owner-to-owner hand-off.
- Requests from non-owners are ignored during OWN. They are re-evaluated in IDLE; no queueing.
- Simultaneous events:
  - req drop and limit reached on the same edge: a single release, with no beat counted for the dropped cycle.
  - A requester dropping req on the same edge it would be granted is not granted, because the grant decision uses sampled req.
- Reset mid-burst: all state returns to reset values on that edge. An in-flight beat is discarded and valid=0 the next cycle.

## Timing
- Grant latency: req rises before edge N in IDLE → gnt visible after edge N.
- Data latency: beat in cycle k (between edges k and k+1) → O/valid valid after edge k+1, one cycle.
- Release: req drops before edge M → gnt=0 after edge M. valid for the final beat is already out.
- Minimum spacing between grants to different requesters is 1 idle cycle.
- Burst limit: with continuous req, the grant spans MAX_BURST cycles, then 1 IDLE cycle.
- No combinational path from inputs to outputs.

## Configuration
- ARB_BURST_LIMIT_EN:
  - Defined: beat counter compared against MAX_BURST; forced release after MAX_BURST beats.
  - Undefined: no forced release; the owner holds until it drops req. The counter is still kept but ignored.
  - Must be undefined only in test benches that prove starvation is impossible for that usage.

## Test plan
- Reset → gnt=0, S=0, O=16'h0000, valid=0, busy=0. Then req=4'b1111 → gnt=4'b0001 one edge later (last=3 after reset).
- req[1] only, B=16'h1234 held for 3 cycles then req[1]=0 → gnt=4'b0010 for 3 cycles, valid high 3 cycles with O=16'h1234, then 1 IDLE cycle with gnt=0.
- req=4'b1111 with each owner releasing after 1 beat; A..D=16'hAAAA/BBBB/CCCC/DDDD → grant order 0,1,2,3,0, separated by IDLE cycles, O sequence AAAA, BBBB, CCCC, DDDD.
- ARB_BURST_LIMIT_EN, MAX_BURST=8, req=4'b0101 held continuously → requester 0 gets 8 beats, IDLE, requester 2 gets 8 beats, IDLE, requester 0. Undefined: requester 0 holds indefinitely (checked over 100 cycles).
- Reset asserted mid-burst on beat 3 of requester 2 with req held → next cycle gnt=0, valid=0, O=0. After reset deasserts, requester 0 has priority if requesting; otherwise requester 2 is re-granted.
- Simultaneous: MAX_BURST=4, req[3] drops in the cycle that would be beat 4 → exactly 3 valid beats, single release, the next grant goes to requester 0 if it is requesting.
